yags_cache_ctrl: RTL

- Sequencer and arbiter for one single-ported YAGS direction cache (Taken or Not-Taken array), with entry format {valid, tag[TAG_W-1:0], ctr[1:0]}.
- Sweeps the array to its initial value after reset.
- Shares the one port between fetch-stage lookups and EX-stage counter updates.
- Buffers EX updates in a small FIFO and performs each as a read-modify-write.

---
 rtl/yags_cache_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/yags_cache_ctrl.sv
// yags_cache_ctrl: sweeps one single-ported YAGS direction array after reset, then shares
// its port between fetch lookups and FIFO-buffered read-modify-write counter updates.
module yags_cache_ctrl #(
  parameter int         INDEX_W    = 10,
  parameter int         TAG_W      = 9,
  parameter int         Q_DEPTH    = 4,
  parameter int         STARVE_MAX = 8,
  parameter logic [1:0] INIT_CTR   = 2'b10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_req_i,
  input  logic [INDEX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               lookup_ready_o,
  output logic               lookup_valid_o,
  output logic               lookup_hit_o,
  output logic               lookup_pred_o,
  input  logic               upd_valid_i,
  input  logic [INDEX_W-1:0] upd_index_i,
  input  logic [TAG_W-1:0]   upd_tag_i,
  input  logic               upd_taken_i,
  input  logic               upd_alloc_i,
  output logic               upd_ready_o,
  output logic [7:0]         ovf_cnt_o,
  output logic               init_done_o,
  output logic               arr_en_o,
  output logic               arr_we_o,
  output logic [INDEX_W-1:0] arr_addr_o,
  output logic [TAG_W+2:0]   arr_wdata_o,
  input  logic [TAG_W+2:0]   arr_rdata_i
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_e;
  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               taken;
    logic               alloc;
  } upd_t;
  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               init_done_q, init_done_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         ovf_q;
  logic               lk_valid_q;
  logic [TAG_W-1:0]   lk_tag_q;
  upd_t               fifo_q [Q_DEPTH];
  upd_t               head;
  logic               full, empty, pop, push, force_drain, grant;
  logic               r_valid, upd_hit;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_ctr, ctr_n;
  assign head        = fifo_q[rd_ptr_q];
  assign full        = cnt_q == CW'(Q_DEPTH);
  assign empty       = cnt_q == '0;
  assign pop         = state_q == UPD_WR;
  assign force_drain = full || (!empty && starve_q == SW'(STARVE_MAX));
  assign grant       = rst_n && state_q == IDLE && lookup_req_i && !force_drain;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign upd_ready_o    = rst_n && (!full || pop);
  assign push           = upd_valid_i && upd_ready_o;
  assign lookup_ready_o = rst_n && state_q == IDLE && !force_drain;
  assign r_valid = arr_rdata_i[TAG_W+2];
  assign r_tag   = arr_rdata_i[TAG_W+1:2];
  assign r_ctr   = arr_rdata_i[1:0];
  assign upd_hit = r_valid && r_tag == head.tag;
  assign ctr_n   = head.taken ? (&r_ctr ? r_ctr : r_ctr + 2'd1) : (|r_ctr ? r_ctr - 2'd1 : r_ctr);
  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_valid_q && r_valid && r_tag == lk_tag_q;
  assign lookup_pred_o  = lookup_hit_o && r_ctr[1];
  assign ovf_cnt_o      = ovf_q;
  assign init_done_o    = init_done_q;
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    init_done_d = init_done_q;
    arr_en_o    = 1'b0;
    arr_we_o    = 1'b0;
    arr_addr_o  = '0;
    arr_wdata_o = '0;
    case (state_q)
      INIT: begin
        arr_en_o    = 1'b1;
        arr_we_o    = 1'b1;
        arr_addr_o  = sweep_q;
        arr_wdata_o = {1'b0, {TAG_W{1'b0}}, INIT_CTR};
        sweep_d     = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (grant) begin
          arr_en_o   = 1'b1;
          arr_addr_o = lookup_index_i;
          starve_d   = empty ? '0 : starve_q + 1'b1;
        end else if (!empty) begin
          arr_en_o   = 1'b1;
          arr_addr_o = head.idx;
          state_d    = UPD_WR;
          starve_d   = '0;
        end else begin
          starve_d   = '0;
        end
      end
      UPD_WR: begin
        arr_en_o    = upd_hit || head.alloc;
        arr_we_o    = upd_hit || head.alloc;
        arr_addr_o  = head.idx;
        arr_wdata_o = {1'b1, head.tag, upd_hit ? ctr_n : (head.taken ? 2'b10 : 2'b01)};
        state_d     = IDLE;
      end
      default: state_d = INIT;
    endcase
    // Keep the array port quiet while reset is held
    if (!rst_n) begin
      arr_en_o    = 1'b0;
      arr_we_o    = 1'b0;
      arr_addr_o  = '0;
      arr_wdata_o = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      lk_valid_q  <= 1'b0;
      lk_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_q + PW'(push);
      rd_ptr_q    <= rd_ptr_q + PW'(pop);
      cnt_q       <= cnt_q + CW'(push) - CW'(pop);
      ovf_q       <= (upd_valid_i && !upd_ready_o && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
      lk_valid_q  <= grant;
      lk_tag_q    <= grant ? lookup_tag_i : lk_tag_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{idx: upd_index_i, tag: upd_tag_i, taken: upd_taken_i, alloc: upd_alloc_i};
  end
endmodule
